cv32e40p_ft_error_monitor: RTL and testbench

Collects the `error_detected` flags produced by the TMR voter wrappers (multiplier, ALU, register file, and similar) and turns them into software-visible fault information. For each source it keeps a sticky status bit, a saturating event counter and a consecutive-cycle run length, and it records the first error seen. A three-state fault FSM tracks the overall fault level and raises an interrupt pulse on each escalation. Read-out uses a registered 1-cycle read port consumed by the CSR/debug logic.

---
 rtl/cv32e40p_pkg.sv | 21 ++
 rtl/cv32e40p_ft_err_counter.sv | 73 +++++++
 rtl/cv32e40p_ft_error_monitor.sv | 152 +++++++++++++++
 tb/tb_cv32e40p_ft_error_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_pkg.sv
// ============================================================================
// Module      : cv32e40p_pkg
// Description : Shared fault-tolerance types and constants for the FT monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40p_pkg;

    typedef enum logic [1:0] {
        FT_OK         = 2'b00,
        FT_TRANSIENT  = 2'b01,
        FT_PERSISTENT = 2'b10
    } ft_state_e;

    localparam int FT_REC_VALID_BIT = 31;
    localparam int FT_STATE_LSB     = 16;

endpackage

`default_nettype wire

// File: rtl/cv32e40p_ft_err_counter.sv
// ============================================================================
// Module      : cv32e40p_ft_err_counter
// Description : Per-source edge counter, consecutive-cycle run counter, sticky.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_ft_err_counter #(
    parameter int CNT_W       = 8,
    parameter int PERSIST_THR = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             flag,
    output logic [CNT_W-1:0] count,
    output logic             sticky,
    output logic             run_hit
);

    localparam int                RUN_W     = $clog2(PERSIST_THR + 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;
    localparam logic [RUN_W-1:0]  c_RUN_THR = RUN_W'(PERSIST_THR);

    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic [RUN_W-1:0] r_run;
    logic             r_sticky;

    logic             w_edge;
    logic [CNT_W-1:0] w_count_base;
    logic [CNT_W-1:0] w_count_nxt;
    logic [RUN_W-1:0] w_run_base;
    logic [RUN_W-1:0] w_run_nxt;

    // A clear makes the old state invisible, so a flag high alongside it is a fresh edge.
    assign w_edge       = flag & ~(r_prev & ~clr);
    assign w_count_base = clr ? '0 : r_count;
    assign w_run_base   = clr ? '0 : r_run;

    always_comb begin
        w_count_nxt = w_count_base;
        w_run_nxt   = '0;
        if (w_edge && (w_count_base != c_CNT_MAX)) begin
            w_count_nxt = w_count_base + 1'b1;
        end
        if (flag) begin
            w_run_nxt = (w_run_base == c_RUN_THR) ? w_run_base : w_run_base + 1'b1;
        end
    end

    // Asserted in the cycle whose edge brings the run counter to threshold.
    assign run_hit = flag && (w_run_nxt == c_RUN_THR);
    assign count   = r_count;
    assign sticky  = r_sticky;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev   <= 1'b0;
            r_count  <= '0;
            r_run    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_prev   <= flag;
            r_count  <= w_count_nxt;
            r_run    <= w_run_nxt;
            r_sticky <= (r_sticky & ~clr) | flag;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cv32e40p_ft_error_monitor.sv
// ============================================================================
// Module      : cv32e40p_ft_error_monitor
// Description : TMR voter error collector: per-source counters, fault FSM,
//               first-error record and registered read port.
//               Optional timestamp: define CV32E40P_FT_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_ft_error_monitor
    import cv32e40p_pkg::*;
#(
    parameter int  NSRC        = 4,
    parameter int  CNT_W       = 8,
    parameter int  PERSIST_THR = 16,
    localparam int AW          = $clog2(NSRC + 2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] error_detected_i,
    input  logic            clear_i,
    input  logic            rd_req_i,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [31:0]     rd_data_o,
    output logic            rd_valid_o,
    output logic            irq_o,
    output logic [1:0]      fault_state_o
);

    logic [CNT_W-1:0] w_count [NSRC];
    logic [NSRC-1:0]  w_sticky;
    logic [NSRC-1:0]  w_run_hit;

    ft_state_e        r_state;
    ft_state_e        w_state_cur;
    ft_state_e        w_state_nxt;
    logic             r_irq;

    logic             r_rec_valid;
    logic [7:0]       r_rec_idx;
    logic [22:0]      r_rec_ts;
    logic [7:0]       w_low_idx;
    logic [22:0]      w_ts;

    logic [31:0]      w_rd_mux;
    logic [31:0]      r_rd_data;
    logic             r_rd_valid;

    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            cv32e40p_ft_err_counter #(
                .CNT_W       (CNT_W),
                .PERSIST_THR (PERSIST_THR)
            ) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clear_i),
                .flag    (error_detected_i[i]),
                .count   (w_count[i]),
                .sticky  (w_sticky[i]),
                .run_hit (w_run_hit[i])
            );
        end
    endgenerate

`ifdef CV32E40P_FT_TIMESTAMP_EN
    logic [31:0] r_cycle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_ts = r_cycle[22:0];
`else
    assign w_ts = '0;
`endif

    // Clear (and the unused encoding) collapse to OK before the transition is evaluated.
    always_comb begin
        w_state_cur = FT_OK;
        if (!clear_i && (r_state == FT_TRANSIENT || r_state == FT_PERSISTENT)) begin
            w_state_cur = r_state;
        end
        w_state_nxt = w_state_cur;
        case (w_state_cur)
            FT_OK:         if (|error_detected_i) w_state_nxt = FT_TRANSIENT;
            FT_TRANSIENT:  if (|w_run_hit) w_state_nxt = FT_PERSISTENT;
            default:       w_state_nxt = w_state_cur;
        endcase
    end

    always_comb begin
        w_low_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (error_detected_i[i]) w_low_idx = 8'(i);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (rd_addr_i == AW'(i)) w_rd_mux = 32'(w_count[i]);
        end
        if (rd_addr_i == AW'(NSRC)) begin
            w_rd_mux[NSRC-1:0]                   = w_sticky;
            w_rd_mux[FT_STATE_LSB+1:FT_STATE_LSB] = r_state;
        end
        if (rd_addr_i == AW'(NSRC + 1)) begin
            w_rd_mux = {r_rec_valid, r_rec_ts, r_rec_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FT_OK;
            r_irq       <= 1'b0;
            r_rec_valid <= 1'b0;
            r_rec_idx   <= '0;
            r_rec_ts    <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_irq      <= (w_state_nxt != w_state_cur);
            r_rd_valid <= rd_req_i;
            if (rd_req_i) begin
                r_rd_data <= w_rd_mux;
            end
            if ((!r_rec_valid || clear_i) && (|error_detected_i)) begin
                r_rec_valid <= 1'b1;
                r_rec_idx   <= w_low_idx;
                r_rec_ts    <= w_ts;
            end else if (clear_i) begin
                r_rec_valid <= 1'b0;
                r_rec_idx   <= '0;
                r_rec_ts    <= '0;
            end
        end
    end

    assign rd_data_o     = r_rd_data;
    assign rd_valid_o    = r_rd_valid;
    assign irq_o         = r_irq;
    assign fault_state_o = r_state;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_ft_error_monitor.sv
// ============================================================================
// Module      : tb_cv32e40p_ft_error_monitor
// Description : Directed self-checking bench for the FT error monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40p_ft_error_monitor;

    localparam int NSRC = 4;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NSRC-1:0] error_detected_i = '0;
    logic            clear_i = 1'b0;
    logic            rd_req_i = 1'b0;
    logic [AW-1:0]   rd_addr_i = '0;
    logic [31:0]     rd_data_o;
    logic            rd_valid_o;
    logic            irq_o;
    logic [1:0]      fault_state_o;

    int          n_asserts = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    logic [31:0] tcyc = '0;
    logic [22:0] ts;

    cv32e40p_ft_error_monitor #(
        .NSRC        (NSRC),
        .CNT_W       (8),
        .PERSIST_THR (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .error_detected_i (error_detected_i),
        .clear_i          (clear_i),
        .rd_req_i         (rd_req_i),
        .rd_addr_i        (rd_addr_i),
        .rd_data_o        (rd_data_o),
        .rd_valid_o       (rd_valid_o),
        .irq_o            (irq_o),
        .fault_state_o    (fault_state_o)
    );

    always #5 clk = ~clk;

    // Reference cycle counter, same reset and wrap behaviour as the timestamp.
    always @(posedge clk) tcyc <= !rst_n ? 32'd0 : tcyc + 32'd1;

    function automatic logic [22:0] ts_now();
`ifdef CV32E40P_FT_TIMESTAMP_EN
        return tcyc[22:0];
`else
        return 23'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] exp);
        rd_req_i  = 1'b1;
        rd_addr_i = a;
        exp_q.push_back(exp);
        step();
        rd_req_i = 1'b0;
        chk("rd_valid", 32'(rd_valid_o), 32'd1);
        if (rd_valid_o && exp_q.size() > 0) chk("rd_data", rd_data_o, exp_q.pop_front());
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_state", 32'(fault_state_o), 32'd0);
        chk("rst_irq", 32'(irq_o), 32'd0);
        chk("rst_valid", 32'(rd_valid_o), 32'd0);
        chk("rst_data", rd_data_o, 32'd0);
        rst_n = 1'b1;
        for (int a = 0; a < 6; a++) rd(AW'(a), 32'd0);
        for (int k = 0; k < 4; k++) step();

        // Single-cycle pulse on source 2
        error_detected_i = 4'b0100;
        ts = ts_now();
        step();
        error_detected_i = '0;
        chk("pulse_state", 32'(fault_state_o), 32'd1);
        chk("pulse_irq", 32'(irq_o), 32'd1);
        step();
        chk("pulse_irq_off", 32'(irq_o), 32'd0);
        rd(3'd2, 32'd1);
        rd(3'd4, 32'h0001_0004);
        rd(3'd5, {1'b1, ts, 8'd2});
        step();
        chk("hold_valid", 32'(rd_valid_o), 32'd0);
        chk("hold_data", rd_data_o, {1'b1, ts, 8'd2});

        // Source 0 held high until persistent
        do_clear();
        chk("clr_state", 32'(fault_state_o), 32'd0);
        chk("clr_irq", 32'(irq_o), 32'd0);
        error_detected_i = 4'b0001;
        ts = ts_now();
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("run_state_%0d", k), 32'(fault_state_o), (k < 16) ? 32'd1 : 32'd2);
            chk($sformatf("run_irq_%0d", k), 32'(irq_o), (k == 1 || k == 16) ? 32'd1 : 32'd0);
        end
        error_detected_i = '0;
        step();
        chk("persist_stay", 32'(fault_state_o), 32'd2);
        chk("persist_irq_off", 32'(irq_o), 32'd0);
        rd(3'd0, 32'd1);
        rd(3'd4, 32'h0002_0001);
        rd(3'd5, {1'b1, ts, 8'd0});

        // Saturation of source 1 counter
        do_clear();
        ts = ts_now();
        for (int k = 0; k < 300; k++) begin
            error_detected_i = 4'b0010;
            step();
            error_detected_i = '0;
            step();
        end
        chk("tog_state", 32'(fault_state_o), 32'd1);
        rd(3'd0, 32'd0);
        rd(3'd1, 32'd255);
        rd(3'd5, {1'b1, ts, 8'd1});

        // Clear coincident with source 3 and a read of the old count
        error_detected_i = 4'b1000;
        clear_i = 1'b1;
        ts = ts_now();
        rd(3'd1, 32'd255);
        clear_i = 1'b0;
        error_detected_i = '0;
        chk("clrerr_state", 32'(fault_state_o), 32'd1);
        chk("clrerr_irq", 32'(irq_o), 32'd1);
        rd(3'd0, 32'd0);
        rd(3'd1, 32'd0);
        rd(3'd2, 32'd0);
        rd(3'd3, 32'd1);
        rd(3'd5, {1'b1, ts, 8'd3});

        // Simultaneous sources 1 and 3
        do_clear();
        error_detected_i = 4'b1010;
        ts = ts_now();
        step();
        error_detected_i = '0;
        rd(3'd5, {1'b1, ts, 8'd1});
        rd(3'd4, 32'h0001_000A);
        rd(3'd7, 32'd0);
        rd(3'd6, 32'd0);

        // Reset asserted mid-run
        error_detected_i = 4'b0001;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        error_detected_i = '0;
        chk("mrst_state", 32'(fault_state_o), 32'd0);
        chk("mrst_irq", 32'(irq_o), 32'd0);
        chk("mrst_valid", 32'(rd_valid_o), 32'd0);
        chk("mrst_data", rd_data_o, 32'd0);
        for (int a = 0; a < 6; a++) rd(AW'(a), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
